// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, reads imem every cycle, and queues {instr, PC+1}.
// Latency: a word fetched in cycle N is at the head in cycle N+1 if the queue was empty.
// Backpressure: stall_d holds the head; when full and not popping, fetch_pc freezes and memory is re-read.
module fetch_prefetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall_d,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rd,
  output logic [31:0]              instr_f,
  output logic [31:0]              pc_plus_one_f,
  output logic                     instr_valid,
  output logic [$clog2(DEPTH):0]   occupancy
);

  // Pointer width indexes DEPTH entries; the count needs one extra bit to represent "full".
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  // Architectural state
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] rd_ptr_q,   rd_ptr_d;
  logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0] count_q,    count_d;

  // Entry storage; contents are only ever observed through instr_valid, so no reset needed.
  logic [31:0] instr_mem_q [DEPTH];
  logic [31:0] ppo_mem_q   [DEPTH];

  // Per-cycle handshake decisions
  logic        full;
  logic        pop;
  logic        push;
  logic [31:0] fetch_pc_plus_one;

  // The memory is always addressed by the current fetch PC.
  assign imem_addr         = fetch_pc_q;
  assign fetch_pc_plus_one = fetch_pc_q + 32'd1;

  // Head view comes purely from registered state; an empty queue presents a nop.
  assign instr_valid   = (count_q != '0);
  assign occupancy     = count_q;
  assign instr_f       = instr_valid ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign pc_plus_one_f = instr_valid ? ppo_mem_q[rd_ptr_q]   : 32'h0;

  // Decode the push/pop handshake and compute next pointers, count and fetch PC.
  always_comb begin
    full       = (count_q == FULL_CNT);
    // A redirect makes the current head wrong-path, so it is dropped rather than popped.
    pop        = instr_valid & ~stall_d & ~redirect;
    // When full, a same-cycle pop frees the slot the incoming word lands in.
    push       = ~redirect & (~full | pop);

    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;

    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push) begin
        wr_ptr_d   = wr_ptr_q + AW'(1);
        fetch_pc_d = fetch_pc_plus_one;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; reset wins over redirect.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Capture the fetched word and its PC+1 into the tail slot on push.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_rd;
      ppo_mem_q[wr_ptr_q]   <= fetch_pc_plus_one;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Bench for fetch_prefetch_queue: directed vector table, in-order delivery sequence,
// and randomized traffic compared against a queue-based reference model.
module tb_fetch_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall_d;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] instr_f;
  logic [31:0] pc_plus_one_f;
  logic        instr_valid;
  logic [2:0]  occupancy;

  int total = 0;
  int bad   = 0;

  fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'd0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .stall_d(stall_d), .imem_addr(imem_addr), .imem_rd(imem_rd), .instr_f(instr_f),
    .pc_plus_one_f(pc_plus_one_f), .instr_valid(instr_valid), .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address a holds 0x1000_0000 + a.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + a;
  endfunction
  assign imem_rd = mem_word(imem_addr);

  // Reference model: the queue of {instr, pc+1} entries and the fetch PC.
  typedef struct packed { logic [31:0] instr; logic [31:0] ppo; } entry_t;
  entry_t      mq[$];
  logic [31:0] mpc;

  task automatic model_edge();
    entry_t e;
    bit     was_full;
    bit     popped;
    if (reset) begin
      mq.delete(); mpc = 32'd0;
    end else if (redirect) begin
      mq.delete(); mpc = redirect_pc;
    end else begin
      was_full = (mq.size() == DEPTH);
      popped   = (mq.size() != 0) && !stall_d;
      if (popped) void'(mq.pop_front());
      if (!was_full || popped) begin
        e.instr = mem_word(mpc);
        e.ppo   = mpc + 32'd1;
        mq.push_back(e);
        mpc = mpc + 32'd1;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model, and land #1 after the edge.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc, input logic st);
    reset = r; redirect = rd; redirect_pc = rpc; stall_d = st;
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".addr"},  imem_addr, mpc);
    chk({tag, ".valid"}, {31'd0, instr_valid}, {31'd0, mq.size() != 0});
    chk({tag, ".instr"}, instr_f,       (mq.size() != 0) ? mq[0].instr : 32'h0);
    chk({tag, ".ppo"},   pc_plus_one_f, (mq.size() != 0) ? mq[0].ppo   : 32'h0);
    chk({tag, ".occ"},   {29'd0, occupancy}, mq.size());
  endtask

  typedef struct {
    logic        rst;
    logic        rdr;
    logic [31:0] rpc;
    logic        stl;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ppo;
    logic [2:0]  e_occ;
  } vec_t;

  vec_t vt[20];

  initial begin
    int n;
    int popped_cnt;

    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'd0; stall_d = 1'b0;

    //        rst  rdr  rpc           stl  addr          v     instr         ppo           occ
    vt[0]  = '{1'b1,1'b0,32'h0,        1'b0,32'h0,        1'b0,32'h0,        32'h0,        3'd0};
    vt[1]  = '{1'b0,1'b0,32'h0,        1'b1,32'h1,        1'b1,32'h1000_0000,32'h1,        3'd1};
    vt[2]  = '{1'b0,1'b0,32'h0,        1'b1,32'h2,        1'b1,32'h1000_0000,32'h1,        3'd2};
    vt[3]  = '{1'b0,1'b0,32'h0,        1'b1,32'h3,        1'b1,32'h1000_0000,32'h1,        3'd3};
    vt[4]  = '{1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h1000_0000,32'h1,        3'd4};
    vt[5]  = '{1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h1000_0000,32'h1,        3'd4};
    vt[6]  = '{1'b0,1'b0,32'h0,        1'b1,32'h4,        1'b1,32'h1000_0000,32'h1,        3'd4};
    vt[7]  = '{1'b0,1'b0,32'h0,        1'b0,32'h5,        1'b1,32'h1000_0001,32'h2,        3'd4};
    vt[8]  = '{1'b0,1'b0,32'h0,        1'b1,32'h5,        1'b1,32'h1000_0001,32'h2,        3'd4};
    vt[9]  = '{1'b0,1'b0,32'h0,        1'b0,32'h6,        1'b1,32'h1000_0002,32'h3,        3'd4};
    vt[10] = '{1'b0,1'b1,32'h40,       1'b0,32'h40,       1'b0,32'h0,        32'h0,        3'd0};
    vt[11] = '{1'b0,1'b0,32'h0,        1'b0,32'h41,       1'b1,32'h1000_0040,32'h41,       3'd1};
    vt[12] = '{1'b0,1'b0,32'h0,        1'b0,32'h42,       1'b1,32'h1000_0041,32'h42,       3'd1};
    vt[13] = '{1'b1,1'b1,32'h80,       1'b0,32'h0,        1'b0,32'h0,        32'h0,        3'd0};
    vt[14] = '{1'b0,1'b1,32'hFFFF_FFFF,1'b0,32'hFFFF_FFFF,1'b0,32'h0,        32'h0,        3'd0};
    vt[15] = '{1'b0,1'b0,32'h0,        1'b0,32'h0,        1'b1,32'h0FFF_FFFF,32'h0,        3'd1};
    vt[16] = '{1'b0,1'b0,32'h0,        1'b0,32'h1,        1'b1,32'h1000_0000,32'h1,        3'd1};
    vt[17] = '{1'b0,1'b1,32'h10,       1'b0,32'h10,       1'b0,32'h0,        32'h0,        3'd0};
    vt[18] = '{1'b0,1'b1,32'h20,       1'b0,32'h20,       1'b0,32'h0,        32'h0,        3'd0};
    vt[19] = '{1'b0,1'b0,32'h0,        1'b0,32'h21,       1'b1,32'h1000_0020,32'h21,       3'd1};

    for (int i = 0; i < 20; i++) begin
      step(vt[i].rst, vt[i].rdr, vt[i].rpc, vt[i].stl);
      chk($sformatf("vec%0d.addr", i),  imem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d.valid", i), {31'd0, instr_valid}, {31'd0, vt[i].e_valid});
      chk($sformatf("vec%0d.instr", i), instr_f, vt[i].e_instr);
      chk($sformatf("vec%0d.ppo", i),   pc_plus_one_f, vt[i].e_ppo);
      chk($sformatf("vec%0d.occ", i),   {29'd0, occupancy}, {29'd0, vt[i].e_occ});
    end

    // Stall fills the queue, then release: every word 0.. arrives once, in order.
    step(1'b1, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
    n = 0;
    popped_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (instr_valid) begin
        chk($sformatf("order%0d.instr", n), instr_f, 32'h1000_0000 + n);
        chk($sformatf("order%0d.ppo", n), pc_plus_one_f, 32'(n + 1));
        n++;
        popped_cnt++;
      end
      step(1'b0, 1'b0, 32'h0, 1'b0);
    end
    chk("order.count", popped_cnt, 12);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic        r, rd, st;
      logic [31:0] rpc;
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 9) == 0);
      st  = ($urandom_range(0, 9) < 4);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + $urandom_range(0, 3)) : $urandom;
      step(r, rd, rpc, st);
      chk_model($sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
